// File: rtl/input_fetcher_pkg.sv
// Shared definitions for the input fetcher: FSM state encoding and frame defaults.
// The width macros normally come from sys_defs.svh; the guarded fallbacks
// below keep this slice self-contained when that header is not on the path.
`ifndef BIN_LEN
`define BIN_LEN 8
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 4
`endif

package input_fetcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } fetch_state_t;

    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_BIN_LEN = `BIN_LEN;
    localparam int DEFAULT_IN_W    = `INPUT_WIDTH;
    localparam int DEFAULT_IN_H    = `INPUT_HEIGHT;

    // Number of values in one default-sized frame.
    localparam int TOTAL_ELEMS = `INPUT_WIDTH * `INPUT_HEIGHT;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding SRAM read data until the consumer takes it.
// Head is read straight from registered storage and forced to zero when
// empty, so the output is clean after reset. Push and pop may coincide.
module prefetch_fifo #(
    parameter int BIN_LEN    = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              push,
    input  logic [BIN_LEN-1:0]                push_data,
    input  logic                              pop,
    output logic [BIN_LEN-1:0]                head,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [BIN_LEN-1:0] storage [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A pop on an empty FIFO is meaningless; ignore it.
    assign do_pop = pop && (occupancy != '0);
    assign head   = (occupancy != '0) ? storage[rd_ptr] : '0;

    // Data storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; overflow would mean the credit logic is broken.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            assert (!(push && !do_pop && occupancy == FULL_OCC));
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/input_fetcher.sv
// Streams one IN_H x IN_W frame from a 1-cycle-latency SRAM in raster order
// to the processing unit. Reads are credit-limited so that FIFO entries plus
// the read in flight never exceed FIFO_DEPTH; with depth 2 this still gives
// one value per cycle while the consumer keeps requesting.
// Handshake: a transfer happens in every cycle with input_req=1 and
// input_ready=1; input_val is the FIFO head during that cycle and the next
// entry (if any) is presented the following cycle.
module input_fetcher
    import input_fetcher_pkg::*;
#(
    parameter int BIN_LEN    = DEFAULT_BIN_LEN,
    parameter int IN_W       = DEFAULT_IN_W,
    parameter int IN_H       = DEFAULT_IN_H,
    parameter int ROW_STRIDE = DEFAULT_IN_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [BIN_LEN-1:0] mem_rd_data,
    input  logic               input_req,
    output logic [BIN_LEN-1:0] input_val,
    output logic               input_ready,
    output logic               busy,
    output logic               done
);

    localparam int COL_W = $clog2(IN_W + 1);
    localparam int ROW_W = $clog2(IN_H + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IN_H - 1);
    // Jump from the last column of one row to column 0 of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_STRIDE - IN_W + 1);

    fetch_state_t      state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic              pop;
    logic              last_issue;
    logic              drain_empty;
    logic [OCC_W-1:0]  occupancy;

    assign input_ready = (occupancy != '0);
    assign pop         = input_req && input_ready;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mem_rd_addr = addr_q;
    assign last_issue  = (row == LAST_ROW) && (col == LAST_COL);

    // Issue only while a credit is free, counting the slot a pop releases now.
    assign mem_rd_en = !reset && (state == STREAM) &&
                       ((int'(occupancy) + int'(inflight) - int'(pop)) < FIFO_DEPTH);

    // Frame is finished once nothing is in flight and the FIFO empties this cycle.
    assign drain_empty = !inflight &&
                         ((occupancy == '0) || (occupancy == OCC_W'(1) && pop));

    // Control FSM: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= STREAM;
                STREAM:  if (mem_rd_en && last_issue) state <= DRAIN;
                DRAIN:   if (drain_empty) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Running address plus row/col position; advances once per issued read.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            row    <= '0;
            col    <= '0;
        end else if (state == IDLE && start) begin
            addr_q <= base_addr;
            row    <= '0;
            col    <= '0;
        end else if (mem_rd_en) begin
            if (col == LAST_COL) begin
                col    <= '0;
                row    <= row + ROW_W'(1);
                addr_q <= addr_q + ROW_STEP;
            end else begin
                col    <= col + COL_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    // Marks that the SRAM returns data this cycle; cleared on reset so late data is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
        end
    end

    prefetch_fifo #(
        .BIN_LEN    (BIN_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head      (input_val),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_input_fetcher.sv
// Bench for input_fetcher: SRAM model, randomized consumer, queue-based reference.
module tb_input_fetcher;

    localparam int BIN_LEN    = 8;
    localparam int IN_W       = 4;
    localparam int IN_H       = 4;
    localparam int ROW_STRIDE = 6;
    localparam int ADDR_W     = 16;
    localparam int N_ELEMS    = IN_W * IN_H;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [BIN_LEN-1:0] mem_rd_data;
    logic               input_req;
    logic [BIN_LEN-1:0] input_val;
    logic               input_ready;
    logic               busy;
    logic               done;

    input_fetcher #(
        .BIN_LEN    (BIN_LEN),
        .IN_W       (IN_W),
        .IN_H       (IN_H),
        .ROW_STRIDE (ROW_STRIDE),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .input_req   (input_req),
        .input_val   (input_val),
        .input_ready (input_ready),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- SRAM model: data one cycle after the strobe ----------------
    function automatic logic [BIN_LEN-1:0] sram_word(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    always @(posedge clock) begin
        mem_rd_data <= mem_rd_en ? sram_word(mem_rd_addr) : BIN_LEN'($urandom);
    end

    // ---------------- scoreboard state ----------------
    logic [ADDR_W-1:0]  addr_q[$];
    logic [BIN_LEN-1:0] exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  frame_active = 1'b0;
    bit  seen_ready;
    int  t_start;
    int  issued;
    int  xfers;
    int  last_xfer;
    int  done_cnt;
    int  done_cyc;
    int  req_mode = 3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- consumer driver ----------------
    initial begin
        input_req = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (req_mode)
                0:       input_req = 1'b1;
                1:       input_req = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: input_req = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        int  outstanding;
        bit  pop_now;
        bit  exp_en;
        if (!reset) begin
            pop_now     = input_req && input_ready;
            outstanding = issued - xfers;
            exp_en      = frame_active && (issued < N_ELEMS) && ((outstanding - int'(pop_now)) < 2);

            check_eq("busy", busy, frame_active);
            check_eq("outstanding_le2", outstanding <= 2, 1);
            check_eq("rd_en_rule", mem_rd_en, exp_en);
            if (mem_rd_en) begin
                check_eq("rd_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check_eq("rd_addr", mem_rd_addr, addr_q.pop_front());
                issued++;
            end
            if (!frame_active) check_eq("idle_ready", input_ready, 0);
            if (frame_active && !seen_ready && input_ready) begin
                check_eq("first_ready", cyc, t_start + 3);
                seen_ready = 1'b1;
            end
            if (pop_now) begin
                check_eq("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("data", input_val, exp_q.pop_front());
                xfers++;
                last_xfer = cyc;
            end
            if (done) begin
                check_eq("done_in_frame", frame_active, 1);
                check_eq("done_after_last", cyc, last_xfer + 1);
                check_eq("all_delivered", exp_q.size(), 0);
                check_eq("all_read", issued, N_ELEMS);
                done_cnt++;
                done_cyc = cyc;
                frame_active = 1'b0;
            end
        end
    end

    // ---------------- frame driver ----------------
    task automatic run_frame(input logic [ADDR_W-1:0] base, input int mode,
                             input bit spurious, input int rst_after);
        logic [ADDR_W-1:0] a;
        exp_q.delete();
        addr_q.delete();
        for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin
                a = base + ADDR_W'(r * ROW_STRIDE + c);
                addr_q.push_back(a);
                exp_q.push_back(sram_word(a));
            end
        end
        req_mode = mode;
        @(posedge clock);
        #1;
        start      = 1'b1;
        base_addr  = base;
        t_start    = cyc;
        seen_ready = 1'b0;
        issued     = 0;
        xfers      = 0;
        last_xfer  = -100;
        done_cnt   = 0;
        done_cyc   = -1;
        @(posedge clock);
        #1;
        start        = 1'b0;
        base_addr    = ADDR_W'($urandom);
        frame_active = 1'b1;
        for (int k = 0; k < 300 && frame_active; k++) begin
            if (rst_after > 0 && xfers >= rst_after) begin
                reset        = 1'b1;
                frame_active = 1'b0;
                exp_q.delete();
                addr_q.delete();
                @(posedge clock);
                #1;
                reset = 1'b0;
                @(negedge clock);
                check_eq("rst_ready", input_ready, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_rd_en", mem_rd_en, 0);
                check_eq("rst_val", input_val, 0);
                return;
            end
            @(posedge clock);
            #1;
            start = spurious && (cyc == t_start + 4);
            if (start) base_addr = base ^ 16'h0040;
        end
        if (frame_active) begin
            check_eq("frame_timeout", frame_active, 0);
            reset        = 1'b1;
            frame_active = 1'b0;
            @(posedge clock);
            #1;
            reset = 1'b0;
        end else begin
            check_eq("done_count", done_cnt, 1);
            if (mode == 0) check_eq("done_time", done_cyc, t_start + 19);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("reset_rd_en", mem_rd_en, 0);
        check_eq("reset_rd_addr", mem_rd_addr, 0);
        check_eq("reset_val", input_val, 0);
        check_eq("reset_ready", input_ready, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);          // requests with no frame active

        run_frame(16'h0100, 0, 1'b0, 0);      // basic frame, continuous requests
        run_frame(16'h0000, 1, 1'b0, 0);      // back-pressure 1,0,0,1
        run_frame(16'hFFFE, 2, 1'b0, 0);      // address wrap, random requests
        run_frame(16'h0230, 0, 1'b0, 5);      // reset after five transfers
        repeat (3) @(posedge clock);
        run_frame(16'h0230, 0, 1'b0, 0);      // clean restart after reset
        run_frame(16'h0400, 0, 1'b1, 0);      // spurious start mid-frame
        for (int i = 0; i < 4; i++) begin
            run_frame(ADDR_W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end
        repeat (4) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/input_fetcher.md
# input_fetcher

Upstream feeder for `processing_unit`. On `start` it streams one input frame of `INPUT_HEIGHT` × `INPUT_WIDTH` binary values from a synchronous input SRAM in raster order. Values reach the unit over the `input_req`/`input_val`/`input_ready` handshake. A small credit-managed prefetch FIFO hides the SRAM read latency, so the stream sustains one value per cycle while the consumer keeps requesting.

## Interface
- `BIN_LEN`, default `` `BIN_LEN ``: width of each input value.
- `IN_W`, default `` `INPUT_WIDTH ``: frame columns.
- `IN_H`, default `` `INPUT_HEIGHT ``: frame rows.
- `ROW_STRIDE`, default `` `INPUT_WIDTH ``: address distance between rows, in words; must be ≥ `IN_W`.
- `ADDR_W`, default 16: SRAM address width.
- `FIFO_DEPTH`, default 2: prefetch entries; minimum 2.

Ports:
- `clock`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high; overrides all other inputs.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `base_addr`  in  `ADDR_W`  frame base address; latched when `start` is accepted.
- `mem_rd_en`  out  1  SRAM read strobe.
- `mem_rd_addr`  out  `ADDR_W`  SRAM read address.
- `mem_rd_data`  in  `BIN_LEN`  read data; valid exactly 1 cycle after `mem_rd_en`.
- `input_req`  in  1  consumer wants a value.
- `input_val`  out  `BIN_LEN`  head-of-FIFO value; valid while `input_ready`=1.
- `input_ready`  out  1  a value is available.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- **Transfer:** a transfer occurs in any cycle where `input_req` and `input_ready` are both 1. That cycle pops the FIFO head, and the next entry appears the following cycle.
- **States:**
  - IDLE → STREAM on `start`. Latch `base_addr`; clear `row`/`col` counters.
  - STREAM: issue reads. After issuing the read for element `IN_H*IN_W - 1`, go to DRAIN.
  - DRAIN: no reads. When the FIFO is empty and no read is in flight, go to DONE.
  - DONE: `done`=1 for this cycle, then IDLE.
- **Read issue:** in STREAM, `mem_rd_en` = (`occupancy` + `inflight` − `pop`) < `FIFO_DEPTH`, where `pop` is the transfer in the current cycle. With depth 2 this sustains one read per cycle.
- **Address:** `mem_rd_addr` = `base_addr` + `row`*`ROW_STRIDE` + `col`, computed modulo 2^`ADDR_W` (wrap-around allowed, no error).
  - `col` increments on each issue.
  - At `col` = `IN_W`−1, `col` returns to 0 and `row` increments.
  - Multiply by a constant only. The address is held in a running register: add 1 per step, and add `ROW_STRIDE` − `IN_W` + 1 at each row wrap.
- **Capture:** a registered `inflight` flag marks the read issued last cycle. When it is set, `mem_rd_data` is pushed into the FIFO.
  - The FIFO can never overflow under the credit rule. Overflow is an assertion failure.
- **`start` outside IDLE** is ignored. A new frame needs a fresh `start` after `done`.
- **`input_req` while `input_ready`=0** simply waits. `input_req` with no frame active never produces a transfer.
- **Reset mid-frame:**
  - Go to IDLE and empty the FIFO.
  - Clear `inflight`, so SRAM data returning the cycle after reset is discarded.
  - Clear the counters.
- **Reset values:** `mem_rd_en`=0, `mem_rd_addr`=0, `input_val`=0, `input_ready`=0, `busy`=0, `done`=0.

## Timing
- `start` is high in cycle t.
  - t+1: STREAM, `mem_rd_en`=1, `mem_rd_addr`=`base_addr`.
  - t+2: data captured.
  - t+3: `input_ready`=1. Start-to-first-value latency is 3 cycles; there is no FIFO bypass.
- Steady state: with `input_req` held high, one transfer every cycle from t+3 to t+2+`IN_H*IN_W`.
- Consumer stall: reads stop once occupancy + inflight reaches `FIFO_DEPTH`. They resume in the same cycle a pop frees a credit.
- `done` is high in the cycle after the FIFO becomes empty in DRAIN. With continuous `input_req`, that is t+3+`IN_H*IN_W`.
- `busy` is high from t+1 through the `done` cycle inclusive.

## Structure
- Shared package `input_fetcher_pkg`:
  - state enum {IDLE, STREAM, DRAIN, DONE};
  - `ADDR_W` default;
  - total-element-count constant derived from `` `INPUT_WIDTH `` × `` `INPUT_HEIGHT ``.
- Width macros come from `sys_defs.svh`.
- One sub-module, `prefetch_fifo`:
  - parameterised synchronous FIFO (`BIN_LEN`, `FIFO_DEPTH`);
  - registered head output, occupancy count;
  - push and pop allowed in the same cycle.
- Control FSM, address generator and credit logic live in `input_fetcher`.

## Test plan
- **Basic frame:** `IN_W`=`IN_H`=4, `base_addr`=0x0100, SRAM word = address low byte, `input_req` tied high → 16 values 0x00..0x0F in order. First `input_ready` at t+3; `done` at t+19; `busy` low at t+20.
- **Row stride:** `ROW_STRIDE`=6, `base_addr`=0 → addresses 0,1,2,3,6,7,8,9,12,… Never reads addresses 4, 5, 10 or 11.
- **Back-pressure:** `input_req` toggles 1,0,0,1 repeating → never more than 2 outstanding (occupancy+inflight ≤ 2). No value lost or duplicated; all 16 delivered in order.
- **Wrap:** `ADDR_W`=16, `base_addr`=0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, …
- **Reset mid-frame:** assert `reset` after 5 transfers, with SRAM returning data the next cycle → `input_ready`=0 and the FIFO is empty. A following `start` restarts at `base_addr` and delivers all 16 values.
- **Spurious start:** pulse `start` during STREAM with a different `base_addr` → ignored; the frame completes at the original addresses with a single `done`.
